// File: rtl/world_step_scheduler_pkg.sv
// Shared types and default constants for the world step scheduler and its key debouncer.
package world_step_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLANK,
        REQ
    } sched_state_t;

    localparam int DEF_V_ACTIVE        = 480;
    localparam int DEF_AUTO_PERIOD     = 25000000;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_DONE_TIMEOUT    = 1024;

endpackage

// File: rtl/world_step_scheduler_key_debouncer.sv
// Two-flop synchronizer plus stable-state debounce for an active-low push-button.
// Emits a one-cycle press pulse on each accepted release->press transition.
module key_debouncer
    import world_step_scheduler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // Accept the new level; only the 1->0 flip counts as a press.
                level <= sync[1];
                cnt   <= '0;
                press <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/world_step_scheduler.sv
// Turns auto-mode ticks or debounced key presses into one world step request each,
// deferred to vertical blanking, with a req/done handshake and timeout.
module world_step_scheduler
    import world_step_scheduler_pkg::*;
#(
    parameter int AUTO_PERIOD     = DEF_AUTO_PERIOD,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int DONE_TIMEOUT    = DEF_DONE_TIMEOUT
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        mode_toggle,
    input  logic        clock_toggle_n,
    input  logic [9:0]  pixel_y,
    input  logic        step_done,
    output logic        step_req,
    output logic        mode,
    output logic [15:0] step_count,
    output logic        overrun,
    output logic        timeout_err
);
    localparam int PW = $clog2(AUTO_PERIOD);
    localparam int TW = $clog2(DONE_TIMEOUT);

    sched_state_t  state;
    logic [1:0]    mode_sync;
    logic          mode_q;
    logic [PW-1:0] presc;
    logic [TW-1:0] wait_cnt;
    logic          pending;
    logic          key_level, key_press;
    logic          step_evt, req_done, req_tmo, abort, pend_clr;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk   (clock_50),
        .reset (reset),
        .key_n (clock_toggle_n),
        .level (key_level),
        .press (key_press)
    );

    assign mode = mode_sync[1];

    always_comb begin
        step_evt = (mode && presc == PW'(AUTO_PERIOD - 1))
                 | (key_press && !key_level && !mode);
        req_done = (state == REQ) && step_done;
        req_tmo  = (state == REQ) && !step_done && (wait_cnt == TW'(DONE_TIMEOUT - 1));
        // A mode flip cancels anything not yet handed to world.
        abort    = (mode != mode_q) && (state != REQ);
        pend_clr = req_done | req_tmo | abort;
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            mode_sync   <= 2'b00;
            mode_q      <= 1'b0;
            presc       <= '0;
            state       <= IDLE;
            pending     <= 1'b0;
            wait_cnt    <= '0;
            step_req    <= 1'b0;
            step_count  <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mode_sync <= {mode_sync[0], mode_toggle};
            mode_q    <= mode;

            if (!mode || presc == PW'(AUTO_PERIOD - 1)) presc <= '0;
            else                                        presc <= presc + 1'b1;

            // An event on the clearing cycle still lands in the freed slot.
            if (step_evt)      pending <= 1'b1;
            else if (pend_clr) pending <= 1'b0;
            if (step_evt && pending && !pend_clr) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (pending && !abort) state <= WAIT_BLANK;
                end
                WAIT_BLANK: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (pixel_y >= 10'(V_ACTIVE)) begin
                        state    <= REQ;
                        step_req <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                REQ: begin
                    if (req_done) begin
                        step_req   <= 1'b0;
                        step_count <= step_count + 16'd1;
                        state      <= IDLE;
                    end else if (req_tmo) begin
                        step_req    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_world_step_scheduler.sv
// Scenario bench for world_step_scheduler with a small world responder and a count scoreboard.
module tb_world_step_scheduler;
    localparam int AUTO_PERIOD     = 10;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int DONE_TIMEOUT    = 8;

    logic        clock_50 = 1'b0;
    logic        reset = 1'b1;
    logic        mode_toggle = 1'b0;
    logic        clock_toggle_n = 1'b1;
    logic [9:0]  pixel_y = 10'd0;
    logic        step_done = 1'b0;
    logic        step_req, mode, overrun, timeout_err;
    logic [15:0] step_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_count = 16'd0;
    logic [15:0] exp_val;
    int          req_rises = 0, req_age = 0, cyc = 0;
    int          last_rise_cyc = 0, prev_rise_cyc = 0;
    bit          req_prev = 1'b0, done_en = 1'b1, late_done = 1'b0;

    world_step_scheduler #(
        .AUTO_PERIOD     (AUTO_PERIOD),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .V_ACTIVE        (480),
        .DONE_TIMEOUT    (DONE_TIMEOUT)
    ) dut (
        .clock_50       (clock_50),
        .reset          (reset),
        .mode_toggle    (mode_toggle),
        .clock_toggle_n (clock_toggle_n),
        .pixel_y        (pixel_y),
        .step_done      (step_done),
        .step_req       (step_req),
        .mode           (mode),
        .step_count     (step_count),
        .overrun        (overrun),
        .timeout_err    (timeout_err)
    );

    always #10 clock_50 = ~clock_50;

    // World stand-in: answers each request with a done pulse one cycle after first seeing it.
    always @(posedge clock_50) begin
        #1;
        cyc++;
        if (step_req) begin
            if (!req_prev) begin
                req_rises++;
                req_age = 0;
                prev_rise_cyc = last_rise_cyc;
                last_rise_cyc = cyc;
            end else begin
                req_age++;
            end
        end
        req_prev  = step_req;
        step_done = (step_req && done_en && req_age == 1) || late_done;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_req_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock_50);
            if (req_rises > base && !step_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic press_key(input int low_cycles);
        clock_toggle_n = 1'b0;
        repeat (low_cycles) @(negedge clock_50);
        clock_toggle_n = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock_50);
        checks++; if (step_req !== 1'b0)       begin errors++; $display("FAIL reset_step_req got %b exp 0", step_req); end
        checks++; if (mode !== 1'b0)           begin errors++; $display("FAIL reset_mode got %b exp 0", mode); end
        checks++; if (step_count !== 16'd0)    begin errors++; $display("FAIL reset_count got %h exp 0", step_count); end
        checks++; if (overrun !== 1'b0)        begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (timeout_err !== 1'b0)    begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout_err); end
        reset = 1'b0;
        @(negedge clock_50);
    endtask

    task automatic test_auto;
        int base = req_rises;
        bit ok;
        pixel_y = 10'd500; done_en = 1'b1; mode_toggle = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_count++; exp_q.push_back(exp_count);
            wait_req_done(base + k, 40, ok);
            checks++; if (!ok) begin errors++; $display("FAIL auto_req_%0d got none exp completed request", k); end
            exp_val = exp_q.pop_front();
            checks++; if (step_count !== exp_val) begin errors++; $display("FAIL auto_count_%0d got %h exp %h", k, step_count, exp_val); end
            if (k > 0) begin
                checks++;
                if (last_rise_cyc - prev_rise_cyc !== AUTO_PERIOD) begin
                    errors++; $display("FAIL auto_period_%0d got %0d exp %0d", k, last_rise_cyc - prev_rise_cyc, AUTO_PERIOD);
                end
            end
        end
        mode_toggle = 1'b0;
        repeat (15) @(negedge clock_50);
        checks++; if (req_rises !== base + 3) begin errors++; $display("FAIL auto_req_total got %0d exp %0d", req_rises - base, 3); end
        checks++; if (overrun !== 1'b0)       begin errors++; $display("FAIL auto_overrun got %b exp 0", overrun); end
    endtask

    task automatic test_blank_deferral;
        int base;
        bit ok;
        reset = 1'b1; @(negedge clock_50); reset = 1'b0; exp_count = 16'd0;
        base = req_rises;
        pixel_y = 10'd100; mode_toggle = 1'b1;
        repeat (26) @(negedge clock_50);
        checks++; if (req_rises !== base) begin errors++; $display("FAIL blank_no_req got %0d exp 0", req_rises - base); end
        checks++; if (overrun !== 1'b1)   begin errors++; $display("FAIL blank_overrun got %b exp 1", overrun); end
        pixel_y = 10'd480; mode_toggle = 1'b0;
        exp_count++; exp_q.push_back(exp_count);
        wait_req_done(base, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL blank_req got none exp completed request"); end
        exp_val = exp_q.pop_front();
        checks++; if (step_count !== exp_val) begin errors++; $display("FAIL blank_count got %h exp %h", step_count, exp_val); end
        repeat (20) @(negedge clock_50);
        checks++; if (req_rises !== base + 1) begin errors++; $display("FAIL blank_one_req got %0d exp 1", req_rises - base); end
    endtask

    task automatic test_manual;
        int base = req_rises;
        bit ok;
        pixel_y = 10'd500; done_en = 1'b1;
        press_key(2);
        repeat (12) @(negedge clock_50);
        checks++; if (req_rises !== base) begin errors++; $display("FAIL manual_glitch got %0d exp 0", req_rises - base); end
        exp_count++; exp_q.push_back(exp_count);
        press_key(6);
        wait_req_done(base, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL manual_req got none exp completed request"); end
        exp_val = exp_q.pop_front();
        checks++; if (step_count !== exp_val) begin errors++; $display("FAIL manual_count got %h exp %h", step_count, exp_val); end
        repeat (12) @(negedge clock_50);
        checks++; if (req_rises !== base + 1) begin errors++; $display("FAIL manual_one_req got %0d exp 1", req_rises - base); end
        base = req_rises;
        exp_count++; exp_q.push_back(exp_count);
        press_key(50);
        repeat (12) @(negedge clock_50);
        checks++; if (req_rises !== base + 1) begin errors++; $display("FAIL manual_hold got %0d exp 1", req_rises - base); end
        exp_val = exp_q.pop_front();
        checks++; if (step_count !== exp_val) begin errors++; $display("FAIL manual_hold_count got %h exp %h", step_count, exp_val); end
    endtask

    task automatic test_timeout;
        int base = req_rises;
        int hi = 0;
        bit ok;
        done_en = 1'b0;
        press_key(6);
        for (int i = 0; i < 30; i++) begin
            if (step_req) break;
            @(negedge clock_50);
        end
        while (step_req && hi < 40) begin
            hi++;
            @(negedge clock_50);
        end
        checks++; if (hi !== DONE_TIMEOUT)     begin errors++; $display("FAIL timeout_len got %0d exp %0d", hi, DONE_TIMEOUT); end
        checks++; if (timeout_err !== 1'b1)    begin errors++; $display("FAIL timeout_err got %b exp 1", timeout_err); end
        checks++; if (step_count !== exp_count) begin errors++; $display("FAIL timeout_count got %h exp %h", step_count, exp_count); end
        repeat (12) @(negedge clock_50);
        done_en = 1'b1;
        base = req_rises;
        exp_count++; exp_q.push_back(exp_count);
        press_key(6);
        wait_req_done(base, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_recover got none exp completed request"); end
        exp_val = exp_q.pop_front();
        checks++; if (step_count !== exp_val) begin errors++; $display("FAIL timeout_recover_count got %h exp %h", step_count, exp_val); end
        repeat (12) @(negedge clock_50);
    endtask

    task automatic test_reset_in_req;
        int base = req_rises;
        done_en = 1'b0;
        press_key(6);
        for (int i = 0; i < 30; i++) begin
            if (step_req) break;
            @(negedge clock_50);
        end
        checks++; if (step_req !== 1'b1) begin errors++; $display("FAIL rstreq_issue got %b exp 1", step_req); end
        reset = 1'b1;
        @(negedge clock_50);
        checks++; if (step_req !== 1'b0)    begin errors++; $display("FAIL rstreq_step_req got %b exp 0", step_req); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL rstreq_count got %h exp 0", step_count); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rstreq_timeout got %b exp 0", timeout_err); end
        checks++; if (overrun !== 1'b0)     begin errors++; $display("FAIL rstreq_overrun got %b exp 0", overrun); end
        reset = 1'b0; exp_count = 16'd0;
        late_done = 1'b1;
        @(negedge clock_50);
        late_done = 1'b0;
        repeat (5) @(negedge clock_50);
        checks++; if (step_count !== exp_count) begin errors++; $display("FAIL rstreq_late_done got %h exp %h", step_count, exp_count); end
        checks++; if (req_rises !== base + 1)   begin errors++; $display("FAIL rstreq_no_new_req got %0d exp 1", req_rises - base); end
        done_en = 1'b1;
    endtask

    task automatic test_mode_switch;
        int base = req_rises;
        bit ok;
        pixel_y = 10'd100; mode_toggle = 1'b1;
        repeat (15) @(negedge clock_50);
        mode_toggle = 1'b0;
        repeat (5) @(negedge clock_50);
        pixel_y = 10'd500;
        repeat (20) @(negedge clock_50);
        checks++; if (req_rises !== base) begin errors++; $display("FAIL modesw_cancel got %0d exp 0", req_rises - base); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL modesw_overrun got %b exp 0", overrun); end
        // Preload the counter just below wrap; the next completion must roll it to zero.
        force dut.step_count = 16'hFFFF;
        #1 release dut.step_count;
        exp_count = 16'hFFFF;
        exp_count++; exp_q.push_back(exp_count);
        press_key(6);
        wait_req_done(base, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_req got none exp completed request"); end
        exp_val = exp_q.pop_front();
        checks++; if (step_count !== exp_val) begin errors++; $display("FAIL wrap_count got %h exp %h", step_count, exp_val); end
    endtask

    initial begin
        test_reset();
        test_auto();
        test_blank_deferral();
        test_manual();
        test_timeout();
        test_reset_in_req();
        test_mode_switch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
